// File: rtl/pixel_scheduler.sv
// Frame scheduler: walks every pixel, hands coordinates to the iteration engine,
// waits out the color-stage latency, then issues one framebuffer write per pixel.
module pixel_scheduler #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int MAX_ITER  = 100,
    parameter int COLOR_LAT = 2,
    parameter int HUE_STEP  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        frame_done,
    output logic        iter_req,
    output logic [9:0]  iter_x,
    output logic [8:0]  iter_y,
    input  logic        iter_ack,
    input  logic        iter_valid,
    input  logic [7:0]  iter_count,
    output logic [6:0]  color_stability,
    output logic [8:0]  color_hue,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    input  logic        fb_ready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_COLOR = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    localparam logic [9:0] X_LAST   = 10'(H_RES - 1);
    localparam logic [8:0] Y_LAST   = 9'(V_RES - 1);
    localparam logic [7:0] STAB_MAX = 8'(MAX_ITER);
    localparam logic [3:0] LAT_INIT = 4'(COLOR_LAT);
    localparam logic [9:0] HUE_INC  = 10'(HUE_STEP);

    logic [2:0] r_state;
    logic [9:0] r_x;
    logic [8:0] r_y;
    logic [6:0] r_stab;
    logic [8:0] r_hue;
    logic [3:0] r_lat;
    logic       r_done;

    logic [6:0] w_stab_sat;
    logic [9:0] w_hue_sum;
    logic [8:0] w_hue_next;
    logic [18:0] w_addr;

    assign w_stab_sat = (iter_count > STAB_MAX) ? STAB_MAX[6:0] : iter_count[6:0];

    // Hue step is at most 359, so a single conditional subtract keeps it in 0..359.
    assign w_hue_sum  = {1'b0, r_hue} + HUE_INC;
    assign w_hue_next = (w_hue_sum >= 10'd360) ? 9'(w_hue_sum - 10'd360) : w_hue_sum[8:0];

    assign w_addr = 19'(r_y) * 19'(H_RES) + 19'(r_x);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_stab  <= '0;
            r_hue   <= '0;
            r_lat   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_x     <= '0;
                r_y     <= '0;
                r_lat   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state <= S_REQ;
                            r_x     <= '0;
                            r_y     <= '0;
                        end
                    end
                    S_REQ: begin
                        // A result strobe arriving with the ack is not taken here.
                        if (iter_ack) r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (iter_valid) begin
                            r_stab  <= w_stab_sat;
                            r_lat   <= LAT_INIT;
                            r_state <= S_COLOR;
                        end
                    end
                    S_COLOR: begin
                        if (r_lat <= 4'd1) begin
                            r_lat   <= '0;
                            r_state <= S_WRITE;
                        end else begin
                            r_lat <= r_lat - 4'd1;
                        end
                    end
                    S_WRITE: begin
                        if (fb_ready) begin
                            if (r_x != X_LAST) begin
                                r_x     <= r_x + 10'd1;
                                r_state <= S_REQ;
                            end else if (r_y != Y_LAST) begin
                                r_x     <= '0;
                                r_y     <= r_y + 9'd1;
                                r_state <= S_REQ;
                            end else begin
                                r_x     <= '0;
                                r_y     <= '0;
                                r_done  <= 1'b1;
                                r_hue   <= w_hue_next;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy            = (r_state != S_IDLE);
    assign iter_req        = (r_state == S_REQ);
    assign fb_we           = (r_state == S_WRITE);
    assign frame_done      = r_done;
    assign iter_x          = r_x;
    assign iter_y          = r_y;
    assign color_stability = r_stab;
    assign color_hue       = r_hue;
    assign fb_addr         = w_addr;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler: small 4x2 frame with handshake model,
// plus a 1x1 instance used to walk the hue through its wrap point.
module tb_pixel_scheduler;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int LAT  = 3;
    localparam int STEP = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort;
    logic        iter_ack, iter_valid, fb_ready;
    logic [7:0]  iter_count;
    logic        busy, frame_done, iter_req, fb_we;
    logic [9:0]  iter_x;
    logic [8:0]  iter_y;
    logic [6:0]  color_stability;
    logic [8:0]  color_hue;
    logic [18:0] fb_addr;

    logic        s2_start;
    logic        w2_busy, w2_done, w2_req, w2_we;
    logic [9:0]  w2_x;
    logic [8:0]  w2_y;
    logic [6:0]  w2_stab;
    logic [8:0]  w2_hue;
    logic [18:0] w2_addr;

    int checks   = 0;
    int failures = 0;
    int exp_hue  = 0;

    int cnts [8] = '{10, 200, 0, 100, 101, 127, 255, 50};
    int stabs[8] = '{10, 100, 0, 100, 100, 100, 100, 50};
    int dlys [8] = '{0, 5, 0, 1, 0, 0, 2, 0};

    always #5 clk = ~clk;

    pixel_scheduler #(.H_RES(H), .V_RES(V), .MAX_ITER(100), .COLOR_LAT(LAT), .HUE_STEP(STEP)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .frame_done(frame_done), .iter_req(iter_req),
        .iter_x(iter_x), .iter_y(iter_y), .iter_ack(iter_ack),
        .iter_valid(iter_valid), .iter_count(iter_count),
        .color_stability(color_stability), .color_hue(color_hue),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_ready(fb_ready)
    );

    pixel_scheduler #(.H_RES(1), .V_RES(1), .MAX_ITER(100), .COLOR_LAT(1), .HUE_STEP(1)) u_wrap (
        .clk(clk), .reset_n(reset_n), .start(s2_start), .abort(1'b0),
        .busy(w2_busy), .frame_done(w2_done), .iter_req(w2_req),
        .iter_x(w2_x), .iter_y(w2_y), .iter_ack(1'b1),
        .iter_valid(1'b1), .iter_count(8'd42),
        .color_stability(w2_stab), .color_hue(w2_hue),
        .fb_we(w2_we), .fb_addr(w2_addr), .fb_ready(1'b1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic serve(input int idx, input int cnt, input int exp_stab, input int rdy_dly, input bit both);
        int n;
        n = 0;
        while (!iter_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_timeout", n < 50, 1);
        check("iter_x", iter_x, idx % H);
        check("iter_y", iter_y, idx / H);
        iter_ack   = 1'b1;
        iter_valid = both;
        iter_count = 8'd7;
        @(negedge clk);
        iter_ack   = 1'b0;
        iter_valid = 1'b0;
        check("req_drop", iter_req, 0);
        start    = 1'b1;
        fb_ready = 1'b1;
        iter_ack = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        fb_ready = 1'b0;
        iter_ack = 1'b0;
        check("wait_hold", busy && !fb_we && !iter_req, 1);
        iter_valid = 1'b1;
        iter_count = 8'(cnt);
        @(negedge clk);
        iter_valid = 1'b0;
        check("stab", color_stability, exp_stab);
        n = 0;
        while (!fb_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("color_lat", n, LAT);
        check("fb_addr", fb_addr, idx);
        for (int k = 0; k < rdy_dly; k++) begin
            @(negedge clk);
            check("we_hold", fb_we, 1);
            check("addr_hold", fb_addr, idx);
            check("x_hold", iter_x, idx % H);
        end
        fb_ready = 1'b1;
        @(negedge clk);
        fb_ready = 1'b0;
        check("frame_done", frame_done, (idx == H * V - 1) ? 1 : 0);
    endtask

    task automatic run_frame(input bit directed);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < H * V; i++) begin
            if (directed) serve(i, cnts[i], stabs[i], dlys[i], i == 2);
            else          serve(i, 10, 10, 0, 1'b0);
        end
        exp_hue = (exp_hue + STEP) % 360;
        check("hue", color_hue, exp_hue);
        check("idle_after", busy, 0);
        @(negedge clk);
        check("done_pulse", frame_done, 0);
    endtask

    initial begin
        int n;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        iter_ack   = 1'b0;
        iter_valid = 1'b0;
        iter_count = 8'd0;
        fb_ready   = 1'b0;
        s2_start   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_req", iter_req, 0);
        check("rst_we", fb_we, 0);
        check("rst_xy", {iter_x, iter_y}, 0);
        check("rst_hue", color_hue, 0);
        check("rst_stab", color_stability, 0);
        check("rst_done", frame_done, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_frame(1'b1);

        // Abort at (2,1): no frame_done, hue kept, coordinates cleared.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) serve(i, 10, 10, 0, 1'b0);
        n = 0;
        while (!iter_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_req_timeout", n < 50, 1);
        check("abort_xy", {22'd0, iter_x, iter_y}, {22'd0, 10'd2, 9'd1});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_req", iter_req, 0);
        check("abort_xy0", {iter_x, iter_y}, 0);
        check("abort_done", frame_done, 0);
        check("abort_hue", color_hue, exp_hue);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_wins", busy, 0);
        @(negedge clk);
        check("abort_nodone", frame_done, 0);
        run_frame(1'b0);

        // Asynchronous reset while waiting on the engine at (3,0).
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) serve(i, 10, 10, 0, 1'b0);
        n = 0;
        while (!iter_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rstw_req_timeout", n < 50, 1);
        iter_ack = 1'b1;
        @(negedge clk);
        iter_ack = 1'b0;
        check("rstw_in_wait", busy && !iter_req && !fb_we, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rstw_busy", busy, 0);
        check("rstw_xy", {iter_x, iter_y}, 0);
        check("rstw_addr", fb_addr, 0);
        check("rstw_stab", color_stability, 0);
        check("rstw_hue", color_hue, 0);
        check("rstw_ctl", {iter_req, fb_we, frame_done}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_hue = 0;
        @(negedge clk);
        run_frame(1'b0);

        // Hue wrap with a step of 5: 355 -> 0.
        for (int f = 0; f < 70; f++) run_frame(1'b0);
        check("hue_355", color_hue, 355);
        run_frame(1'b0);
        check("hue_wrap5", color_hue, 0);

        // Hue wrap with a step of 1 on the 1x1 instance: 359 -> 0.
        for (int f = 0; f < 360; f++) begin
            s2_start = 1'b1;
            @(negedge clk);
            s2_start = 1'b0;
            n = 0;
            while (!w2_done && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("wrap_done_timeout", n < 20, 1);
            if (f == 358) check("hue_359", w2_hue, 359);
        end
        check("hue_wrap1", w2_hue, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
